// File: rtl/act_pkg.sv
// Shared constants and state encoding for the activation LUT loader.
package act_pkg;

    localparam int LUT_WIDTH  = 24;
    localparam int ADDR_WIDTH = 5;
    localparam int LUT_DEPTH  = 16;
    // Config word (q_encode) sits right after the coefficient entries.
    localparam int CFG_ADDR   = LUT_DEPTH;
    localparam int PIPE_LAT   = 4;

    // q_encode field positions inside the config word, 4 bits each.
    localparam int QE_FW      = 4;
    localparam int QE_F2_LSB  = 20;
    localparam int QE_F1_LSB  = 16;
    localparam int QE_F0_LSB  = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_e;

endpackage

// File: rtl/act_drain_cnt.sv
// Reloadable down-counter that tracks how long the activation pipeline has
// been free of new round data. o_zero flags the cycle in which the counter
// runs out, so the owner can leave the drain phase on the following edge.
module act_drain_cnt #(
    parameter int PIPE_LAT = 4,
    parameter int CNT_W    = $clog2(PIPE_LAT + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_en,
    input  logic i_act_vld,
    output logic o_zero
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PIPE_LAT);

    logic [CNT_W-1:0] cnt;

    // Reload on start or on any round-data beat while draining, else count down.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_start || (i_en && i_act_vld)) begin
            cnt <= RELOAD;
        end else if (i_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Last quiet cycle: count reaches zero at this edge with no new beat.
    assign o_zero = i_en && !i_act_vld && (cnt <= CNT_W'(1));

endmodule

// File: rtl/act_lut_loader.sv
// Sequencer that reloads the activation LUT while the datapath is live:
// hold off round data, wait for the pipe to drain, stream 16 coefficients
// plus one q_encode config word into the LUT write port, then release.
module act_lut_loader #(
    parameter int LUT_WIDTH  = act_pkg::LUT_WIDTH,
    parameter int ADDR_WIDTH = act_pkg::ADDR_WIDTH,
    parameter int LUT_DEPTH  = act_pkg::LUT_DEPTH,
    parameter int PIPE_LAT   = act_pkg::PIPE_LAT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_req,
    input  logic                  i_act_vld,
    input  logic                  i_wdat_vld,
    input  logic [LUT_WIDTH-1:0]  i_wdat,
    output logic                  o_wdat_rdy,
    output logic                  o_act_hold,
    output logic                  o_lut_bramctl_en,
    output logic                  o_lut_bramctl_we,
    output logic [ADDR_WIDTH-1:0] o_lut_bramctl_addr,
    output logic [LUT_WIDTH-1:0]  o_lut_bramctl_wdata,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic                  o_err
);

    import act_pkg::state_e;
    import act_pkg::S_IDLE;
    import act_pkg::S_DRAIN;
    import act_pkg::S_LOAD;
    import act_pkg::S_FLUSH;
    import act_pkg::S_DONE;

    // Index of the config word, which is also the last accepted word.
    localparam logic [ADDR_WIDTH-1:0] CFG_IDX = ADDR_WIDTH'(LUT_DEPTH);

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  start;
    logic                  drain_en;
    logic                  drain_zero;
    logic                  hs;
    logic                  wr_q;

    assign start    = (state == S_IDLE) && i_load_req;
    assign drain_en = (state == S_DRAIN);
    assign hs       = i_wdat_vld && o_wdat_rdy;

    act_drain_cnt #(
        .PIPE_LAT (PIPE_LAT)
    ) u_drain (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (start),
        .i_en      (drain_en),
        .i_act_vld (i_act_vld),
        .o_zero    (drain_zero)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: the 17th handshake closes the stream, FLUSH lets its write land.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_load_req)               state_nxt = S_DRAIN;
            S_DRAIN: if (drain_zero)               state_nxt = S_LOAD;
            S_LOAD:  if (hs && (idx == CFG_IDX))   state_nxt = S_FLUSH;
            S_FLUSH:                               state_nxt = S_DONE;
            S_DONE:                                state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; hold already drops in DONE.
    always_comb begin
        o_wdat_rdy  = (state == S_LOAD);
        o_act_hold  = (state == S_DRAIN) || (state == S_LOAD) || (state == S_FLUSH);
        o_busy      = (state != S_IDLE);
        o_load_done = (state == S_DONE);
    end

    // Word index: restarts at LOAD entry, advances per accepted word.
    always_ff @(posedge i_clk) begin
        if (i_rst)                      idx <= '0;
        else if (drain_en && drain_zero) idx <= '0;
        else if (hs)                    idx <= idx + 1'b1;
    end

    // Registered write port: one-cycle latency from handshake to strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q                <= 1'b0;
            o_lut_bramctl_addr  <= '0;
            o_lut_bramctl_wdata <= '0;
        end else begin
            wr_q <= hs;
            if (hs) begin
                o_lut_bramctl_addr  <= idx;
                o_lut_bramctl_wdata <= i_wdat;
            end
        end
    end

    assign o_lut_bramctl_en = wr_q;
    assign o_lut_bramctl_we = wr_q;

    // Sticky protocol error: round data issued while the LUT is being written.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                           o_err <= 1'b0;
        else if (start)                                      o_err <= 1'b0;
        else if (i_act_vld && o_act_hold && (state != S_DRAIN)) o_err <= 1'b1;
    end

endmodule

// File: tb/tb_act_lut_loader.sv
// Bench for act_lut_loader: scenario table plus scoreboard on the LUT write port.
module tb_act_lut_loader;

    localparam int LW = act_pkg::LUT_WIDTH;
    localparam int AW = act_pkg::ADDR_WIDTH;
    localparam int LD = act_pkg::LUT_DEPTH;
    localparam int PL = act_pkg::PIPE_LAT;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          act_vld;
    logic          wdat_vld;
    logic [LW-1:0] wdat;
    logic          wdat_rdy;
    logic          act_hold;
    logic          lut_en;
    logic          lut_we;
    logic [AW-1:0] lut_addr;
    logic [LW-1:0] lut_wdata;
    logic          busy;
    logic          load_done;
    logic          err;

    always #5 clk = ~clk;

    act_lut_loader #(
        .LUT_WIDTH  (LW),
        .ADDR_WIDTH (AW),
        .LUT_DEPTH  (LD),
        .PIPE_LAT   (PL)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_load_req          (load_req),
        .i_act_vld           (act_vld),
        .i_wdat_vld          (wdat_vld),
        .i_wdat              (wdat),
        .o_wdat_rdy          (wdat_rdy),
        .o_act_hold          (act_hold),
        .o_lut_bramctl_en    (lut_en),
        .o_lut_bramctl_we    (lut_we),
        .o_lut_bramctl_addr  (lut_addr),
        .o_lut_bramctl_wdata (lut_wdata),
        .o_busy              (busy),
        .o_load_done         (load_done),
        .o_err               (err)
    );

    typedef struct {
        string         name;
        int            act_at;      // cycle of a drain-phase act pulse, -1 none
        bit            act_in_load; // act pulse at cycle 8 (inside LOAD)
        bit            bubbles;     // wdat_vld only on odd cycles
        bit            req_in_load; // extra load_req at cycle 10
        logic [LW-1:0] base;
        int            exp_start;   // first cycle with rdy, relative to req
        int            exp_done;    // done pulse cycle, relative to req
        bit            exp_err;
    } scen_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wr_t;

    scen_t tbl[5];
    wr_t   sb[$];
    int    checks = 0;
    int    errors = 0;
    int    nhs    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: log a handshake into the scoreboard, then check the write port.
    task automatic cycle();
        bit  hs = wdat_vld && wdat_rdy && !rst;
        wr_t w;
        if (hs) begin
            w.addr = AW'(nhs);
            w.data = wdat;
            sb.push_back(w);
            nhs++;
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            w = sb.pop_front();
            chk("wr_strobe", {30'd0, lut_en, lut_we}, 32'd3);
            chk("wr_addr", 32'(lut_addr), 32'(w.addr));
            chk("wr_data", 32'(lut_wdata), 32'(w.data));
        end else begin
            chk("no_write", {30'd0, lut_en, lut_we}, 32'd0);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ctrl"}, {25'd0, wdat_rdy, act_hold, lut_en, lut_we, busy, load_done, err}, 32'd0);
        chk({name, "_addr"}, 32'(lut_addr), 32'd0);
        chk({name, "_wdata"}, 32'(lut_wdata), 32'd0);
    endtask

    task automatic run_scen(input scen_t s);
        int start = -1;
        int done = -1;
        int hold_gap = 0;
        int early_rdy = 0;
        nhs = 0;
        for (int c = 0; c < 150; c++) begin
            if (c == 0) chk({s.name, "_idle_busy"}, 32'(busy), 32'd0);
            if (c == 1) begin
                chk({s.name, "_hold_rise"}, 32'(act_hold), 32'd1);
                chk({s.name, "_busy_rise"}, 32'(busy), 32'd1);
                chk({s.name, "_err_clr"}, 32'(err), 32'd0);
            end
            if (wdat_rdy && c < s.exp_start) early_rdy++;
            if (wdat_rdy && start < 0) start = c;
            if (c >= 1 && done < 0 && !load_done && !act_hold) hold_gap++;
            if (load_done && done < 0) begin
                done = c;
                chk({s.name, "_hold_at_done"}, 32'(act_hold), 32'd0);
                chk({s.name, "_busy_at_done"}, 32'(busy), 32'd1);
            end
            if (done >= 0 && c == done + 1)
                chk({s.name, "_after_done"}, {28'd0, load_done, busy, act_hold, wdat_rdy}, 32'd0);
            if (done >= 0 && c == done + 3) break;
            load_req = (c == 0) || (s.req_in_load && c == 10);
            act_vld  = (c == s.act_at) || (s.act_in_load && c == 8);
            wdat_vld = s.bubbles ? c[0] : 1'b1;
            wdat     = s.base + LW'(nhs);
            cycle();
        end
        load_req = 1'b0;
        act_vld  = 1'b0;
        wdat_vld = 1'b0;
        chk({s.name, "_load_start"}, 32'(start), 32'(s.exp_start));
        chk({s.name, "_done_cycle"}, 32'(done), 32'(s.exp_done));
        chk({s.name, "_early_rdy"}, 32'(early_rdy), 32'd0);
        chk({s.name, "_hold_gap"}, 32'(hold_gap), 32'd0);
        chk({s.name, "_handshakes"}, 32'(nhs), 32'(LD + 1));
        chk({s.name, "_err"}, 32'(err), 32'(s.exp_err));
        chk({s.name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Best case: DRAIN c1..c4, LOAD c5..c21, FLUSH c22, DONE c23.
        tbl[0] = '{"idle_load",  -1, 1'b0, 1'b0, 1'b0, 24'h000001, 5, 23, 1'b0};
        // Act pulse at c3 restarts the drain: quiet c4..c7, LOAD c8, DONE c26.
        tbl[1] = '{"drain_ext",   3, 1'b0, 1'b0, 1'b0, 24'h100000, 8, 26, 1'b0};
        // Odd-cycle words: handshakes c5..c37, FLUSH c38, DONE c39.
        tbl[2] = '{"bubbles",    -1, 1'b0, 1'b1, 1'b0, 24'h200040, 5, 39, 1'b0};
        tbl[3] = '{"violation",  -1, 1'b1, 1'b0, 1'b0, 24'h3000A0, 5, 23, 1'b1};
        tbl[4] = '{"extra_req",  -1, 1'b0, 1'b0, 1'b1, 24'hABC000, 5, 23, 1'b0};

        rst      = 1'b1;
        load_req = 1'b0;
        act_vld  = 1'b0;
        wdat_vld = 1'b0;
        wdat     = '0;
        cycle();
        cycle();
        chk_idle("reset");
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 5; i++) run_scen(tbl[i]);

        // Reset in the middle of a load, after 8 accepted words.
        nhs      = 0;
        load_req = 1'b1;
        wdat_vld = 1'b1;
        for (int c = 0; c < 40 && nhs < 8; c++) begin
            wdat = 24'h5A0000 + LW'(nhs);
            cycle();
            load_req = 1'b0;
        end
        chk("midrst_words", 32'(nhs), 32'd8);
        chk("midrst_loading", 32'(wdat_rdy), 32'd1);
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        wdat_vld = 1'b0;
        chk_idle("midrst");
        cycle();
        run_scen(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_lut_loader.md
# act_lut_loader

Sequencer that safely reloads the activation LUT BRAM, 16 coefficient entries plus one q_encode config entry, while the activation datapath is live. On a load request it holds off new round data and waits for the activation pipeline to drain. It then accepts exactly 17 words over a valid/ready stream and drives the LUT BRAM write port, pulses done, and releases the hold. It sits between the host/DMA word stream and the LUT write port of the activation stage.

## Interface
- LUT_WIDTH, 24, LUT word width (coefficient A[7:0], B[23:8]; config word carries q_encode fields)
- ADDR_WIDTH, 5, LUT address width
- LUT_DEPTH, 16, coefficient entries; config entry lives at address LUT_DEPTH
- PIPE_LAT, 4, cycles from last issued round-data beat until the activation pipeline is empty

- i_clk  input  1  clock; single clock domain
- i_rst  input  1  reset, synchronous, active-high
- i_load_req  input  1  start a table load (level or pulse; sampled in IDLE only)
- i_act_vld  input  1  round data issued to activation stage this cycle
- i_wdat_vld  input  1  load word valid
- i_wdat  input  LUT_WIDTH  load word
- o_wdat_rdy  output  1  load word ready
- o_act_hold  output  1  upstream must not issue round data
- o_lut_bramctl_en  output  1  LUT write-port enable
- o_lut_bramctl_we  output  1  LUT write strobe
- o_lut_bramctl_addr  output  ADDR_WIDTH  LUT write address
- o_lut_bramctl_wdata  output  LUT_WIDTH  LUT write data
- o_busy  output  1  not in IDLE
- o_load_done  output  1  one-cycle pulse, table fully written
- o_err  output  1  sticky: i_act_vld seen while hold in effect

## Operation
- States: IDLE, DRAIN, LOAD, FLUSH, DONE.
- IDLE: if i_load_req, go DRAIN, clear o_err, load drain counter with PIPE_LAT.
- DRAIN: o_act_hold=1. Counter decrements each cycle and reloads to PIPE_LAT on any i_act_vld. At 0, go LOAD with word index 0.
- LOAD: o_wdat_rdy=1. Each handshake (vld&rdy) registers the word and its index; the index increments.
- Index 0..15 write addresses 0..15. Index 16 writes address 16 (config: q_encode fields [23:20],[19:16],[15:12]).
- Handshake on index 16 drops rdy the next cycle and goes FLUSH. No word beyond 17 is ever accepted.
- FLUSH: completes the registered final write, then goes DONE.
- DONE: o_load_done=1 for one cycle, o_act_hold deasserts the same cycle, then IDLE.
- o_act_hold=1 in DRAIN, LOAD, FLUSH; 0 in IDLE and DONE.
- i_act_vld while o_act_hold=1 and state≠DRAIN sets o_err. The load continues regardless.
- i_load_req outside IDLE is ignored; no queuing.
- i_wdat_vld outside LOAD is ignored (rdy=0).

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-load returns to IDLE. Partially written LUT content is undefined and the host must reload. Hold drops the cycle after reset.
- o_act_hold asserts the cycle after i_load_req is sampled in IDLE.
- Minimum drain is PIPE_LAT cycles in DRAIN with no i_act_vld.
- Write latency: handshake at cycle t gives en=we=1 with addr/wdata at t+1. en and we are otherwise 0.
- Back-to-back words give one write per cycle. Bubbles on i_wdat_vld produce no write.
- Best-case load (no drain, continuous stream): req at t0; DRAIN t1..t1+PIPE_LAT−1; LOAD 17 cycles; FLUSH 1; DONE pulse at t0+PIPE_LAT+19.
- o_busy=1 from the cycle after the IDLE exit through the DONE cycle.

## Structure
- Shared package act_pkg: LUT_WIDTH, ADDR_WIDTH, LUT_DEPTH, CFG_ADDR (=LUT_DEPTH), state encoding, q_encode field positions in the config word.
- One sub-module: act_drain_cnt. It is a reloadable down-counter (PIPE_LAT load on i_act_vld or start) with a zero flag.
- The FSM, index counter and write register live in the top.

## Test plan
- Idle load, PIPE_LAT=4: req, no act traffic, 17 continuous words 0x000001..0x000011. Required: writes to addr 0..16 with matching data on consecutive cycles, done pulse exactly 4+19 cycles after req, hold low afterwards, o_err=0.
- Drain extension: i_act_vld pulses 2 cycles after hold. Required: LOAD entry delayed to 4 cycles after the last pulse, and o_err stays 0.
- Stream bubbles: i_wdat_vld toggles 1,0,1,0. Required: 17 writes with no write on bubble cycles; addresses stay contiguous 0..16.
- Protocol violation: i_act_vld=1 during LOAD. Required: o_err=1 and sticky, load still completes, and o_err clears on the next accepted i_load_req.
- Reset mid-load after 8 words: i_rst one cycle. Required: all outputs 0 the next cycle, state IDLE, and a following full load succeeds.
- Extra/early words: i_wdat_vld held high before req and after the 17th word. Required: rdy=0 outside LOAD, exactly 17 handshakes, and i_load_req during LOAD is ignored with no restart.
